// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
//   state_e  : scheduler FSM state (IDLE, LOAD, HOLD)
//   DIGITS   : digits on the scan display
//   NIB_W    : bits per displayed digit
//   WORD_W   : display word width (one nibble per digit)
//   DIGIT_W  : width of the scan digit index
//   rr_index : modular index helper used by the round-robin arbiter
package seg_disp_pkg;

    localparam int unsigned DIGITS  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned WORD_W  = DIGITS * NIB_W;
    localparam int unsigned DIGIT_W = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    // (base + off) modulo n, with n > 0.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at the source after 'last' and wraps modulo NUM_SRC, so the most
// recently served source has the lowest priority.
// Ports:
//   req         in   NUM_SRC          request vector
//   last        in   clog2(NUM_SRC)   index of the most recently granted source
//   grant       out  clog2(NUM_SRC)   winning index (equals 'last' when nothing requests)
//   grant_valid out  1                at least one request is present
module rr_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last,
    output logic [$clog2(NUM_SRC)-1:0] grant,
    output logic                       grant_valid
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant       = last;
        grant_valid = 1'b0;
        // Offsets 1..NUM_SRC: the last offset revisits 'last' itself.
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = rr_index(32'(last), k, NUM_SRC);
            if (!grant_valid && req[IDX_W'(idx)]) begin
                grant       = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_sched.sv
// Scheduler for the 8-digit seven-segment scan display.
// Shares the display word among NUM_SRC debug requesters with round-robin rotation and a
// per-page dwell time, and generates the scan strobe and digit index for the decoder.
// Optional feature: define BLANK_STALE_EN to add the disp_blank output.
// Ports:
//   clk        in   1                system clock, rising edge
//   rst_n      in   1                asynchronous active-low reset
//   src_req    in   NUM_SRC          per-source request, held until its ack
//   src_data   in   NUM_SRC*32       source words, source i at [32*i+31:32*i]
//   src_ack    out  NUM_SRC          one-cycle ack, word of that source latched
//   page_next  in   1                one-cycle pulse: advance page now (ignored in IDLE)
//   lock       in   1                suppress dwell expiry
//   disp_data  out  32               word currently shown
//   disp_src   out  clog2(NUM_SRC)   index of source shown
//   scan_tick  out  1                one-cycle strobe every CLK_DIV cycles
//   digit_sel  out  3                active digit, 0 = most significant nibble
//   busy       out  1                FSM not in IDLE
//   disp_blank out  1                (BLANK_STALE_EN only) display content is stale
module seg_display_sched
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned CLK_DIV    = 50000,
    parameter int unsigned HOLD_TICKS = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC-1:0]          src_req,
    input  logic [NUM_SRC*WORD_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_ack,
    input  logic                        page_next,
    input  logic                        lock,
    output logic [WORD_W-1:0]           disp_data,
    output logic [$clog2(NUM_SRC)-1:0]  disp_src,
    output logic                        scan_tick,
    output logic [DIGIT_W-1:0]          digit_sel,
    output logic                        busy
`ifdef BLANK_STALE_EN
    ,
    output logic                        disp_blank
`endif
);

    localparam int unsigned IDX_W   = $clog2(NUM_SRC);
    localparam int unsigned PRE_W   = $clog2(CLK_DIV);
    localparam int unsigned DWELL_W = $clog2(HOLD_TICKS + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(CLK_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(HOLD_TICKS - 1);
    localparam logic [IDX_W-1:0]   LAST_INIT  = IDX_W'(NUM_SRC - 1);

    state_e             state_q;
    logic [PRE_W-1:0]   presc_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_q;

    logic [IDX_W-1:0]   arb_grant;
    logic               arb_valid;
    logic [NUM_SRC-1:0] grant_onehot;
    logic               advance;

    logic [WORD_W-1:0]  words [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
        assign words[i] = src_data[WORD_W*i +: WORD_W];
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index: free-running, independent of the FSM.
    // ------------------------------------------------------------------
    assign scan_tick = (presc_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            digit_sel <= '0;
        end else if (scan_tick) begin
            presc_q   <= '0;
            digit_sel <= digit_sel + 1'b1;
        end else begin
            presc_q   <= presc_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    rr_arbiter #(
        .NUM_SRC(NUM_SRC)
    ) u_arb (
        .req        (src_req),
        .last       (last_q),
        .grant      (arb_grant),
        .grant_valid(arb_valid)
    );

    always_comb begin
        grant_onehot            = '0;
        grant_onehot[arb_grant] = 1'b1;
    end

    // A coincident page_next and expiry is one event, not two.
    assign advance = page_next || (scan_tick && (dwell_q == DWELL_LAST) && !lock);

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= LAST_INIT;
            dwell_q   <= '0;
            src_ack   <= '0;
            disp_data <= '0;
            disp_src  <= '0;
            busy      <= 1'b0;
        end else begin
            src_ack <= '0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_grant;
                        src_ack <= grant_onehot;
                        busy    <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // Word is taken even if the requester has already dropped req.
                    disp_data <= words[grant_q];
                    disp_src  <= grant_q;
                    last_q    <= grant_q;
                    dwell_q   <= '0;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (advance) begin
                        if (arb_valid) begin
                            grant_q <= arb_grant;
                            src_ack <= grant_onehot;
                            state_q <= LOAD;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (scan_tick && (dwell_q != DWELL_LAST)) begin
                        // Saturate while locked so expiry fires on the first tick after unlock.
                        dwell_q <= dwell_q + 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BLANK_STALE_EN
    // Stale until the first page loads, and again once a page expires with nobody waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_blank <= 1'b1;
        end else if (state_q == LOAD) begin
            disp_blank <= 1'b0;
        end else if ((state_q == HOLD) && advance && !arb_valid) begin
            disp_blank <= 1'b1;
        end
    end
`endif

endmodule
